detect_event_log: RTL and testbench
===================================

// Module: detect_event_log
// PURPOSE
//  - Sits directly downstream of the serial sequence detector and consumes its 1-cycle 'detected' pulse.
//  - Stamps each pulse with a free-running cycle timestamp and queues it in a small FIFO.
//  - Software/testbench side drains events over a valid/ready interface.
//  - Keeps saturating totals of events seen and events dropped on overflow.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  TS_W   16  timestamp width; counter wraps modulo 2^TS_W
//  CNT_W  8   width of evt_count / drop_count; both saturate at 2^CNT_W-1
// PORTS
//  clk         in   1                  single clock, rising edge
//  reset_n     in   1                  asynchronous, active-low reset
//  detected    in   1                  detection pulse from the sequence detector, sampled each rising edge
//  clear       in   1                  synchronous flush/zero, active-high
//  evt_valid   out  1                  head-of-FIFO entry available
//  evt_ready   in   1                  consumer accepts head when evt_valid=1
//  evt_ts      out  TS_W               timestamp of head entry; 0 when FIFO empty
//  level       out  $clog2(DEPTH)+1    current FIFO occupancy
//  evt_count   out  CNT_W              pulses seen since reset/clear, dropped pulses included
//  drop_count  out  CNT_W              pulses lost because the FIFO was full
//  overflow    out  1                  sticky; set on the first drop
// BEHAVIOUR
//  - Reset (reset_n=0, async, immediate): ts, FIFO pointers and level, evt_count, drop_count, overflow all 0.
//    evt_valid=0, evt_ts=0. No output depends on memory contents while reset is asserted.
//  - Timestamp: ts increments every cycle, wrapping from 2^TS_W-1 to 0.
//    A pulse sampled at an edge captures the pre-increment ts value.
//  - Push: detected=1 at an edge, with clear=0:
//    evt_count++ (saturating); entry written when (level<DEPTH) or (pop in the same cycle).
//  - Push refused (full and no pop): drop_count++ (saturating), overflow<=1, FIFO contents unchanged.
//  - Pop: evt_valid & evt_ready at an edge removes the head. evt_ready ignored when evt_valid=0.
//  - Latency: pulse at edge N -> evt_valid=1 and level updated after edge N (FIFO was empty).
//    No combinational path from detected to any output.
//  - Simultaneous push+pop: level unchanged; holds when full and when level=1.
//  - Pointers wrap modulo DEPTH. Ordering is strict FIFO.
//  - evt_valid = (level!=0), registered-derived. evt_ts shows the head entry combinationally from registered state.
//  - clear=1 at an edge: ts, pointers, level, counts and overflow -> 0.
//    Any same-cycle detected or pop is ignored: not counted, not stored.
//  - Reset mid-drain: everything aborts to reset state; no partial pop.
//  - Counter saturation: at max value, further increments hold the value; no wrap.
// CONFIGURATION
//  EVLOG_GAP_EN defined:
//    - Adds port evt_gap (out, TS_W) and a TS_W-wide field to each FIFO entry.
//    - gap = (ts_now - ts_prev_accepted) mod 2^TS_W.
//    - First accepted event after reset/clear has gap=0; dropped events do not update ts_prev.
//    - evt_gap = 0 when FIFO empty.
//  EVLOG_GAP_EN undefined: port, storage and ts_prev register absent; all other behaviour identical.
// TESTING
//  T1 Reset, pulse when ts=5, evt_ready=0 -> next cycle evt_valid=1, evt_ts=5, level=1, evt_count=1.
//  T2 DEPTH=4, pulses at ts=2,4,6,8,10, ready=0 -> level=4, evt_count=5, drop_count=1, overflow=1;
//     drain -> 2,4,6,8 in order, then evt_valid=0.
//  T3 FIFO full, detected=1 and evt_ready=1 same edge -> level stays 4, drop_count unchanged, new ts becomes tail.
//  T4 level=3, clear=1 with detected=1 same edge -> level=0, evt_count=0, overflow=0, evt_valid=0; next ts sampled =0.
//  T5 reset_n driven low between edges during a drain -> evt_valid, level, counts drop to 0 before next edge.
//  T6 EVLOG_GAP_EN, TS_W=4: pulses at ts=14 then ts=2 (after wrap) -> evt_gap 0 then 4.
//     Counters saturate: CNT_W=2, 5 pulses -> evt_count=3.

Source files
------------

// File: rtl/detect_event_log.sv
// ---------------------------------------------------------------------------
// detect_event_log
//
// Purpose:
//   Sits downstream of the serial sequence detector. Each 1-cycle 'detected'
//   pulse is stamped with a free-running cycle timestamp and queued in a small
//   FIFO. A consumer drains entries over a valid/ready handshake. Saturating
//   totals of events seen and events dropped on overflow are kept alongside a
//   sticky overflow flag.
//
// Optional feature (macro EVLOG_GAP_EN):
//   When defined, each entry also stores the distance in cycles from the
//   previously accepted event. That value is presented on evt_gap. When the
//   macro is undefined, the port, the per-entry field and the previous-
//   timestamp register are all absent.
//
// Ports:
//   clk         in   1                rising-edge clock
//   reset_n     in   1                asynchronous active-low reset
//   detected    in   1                detection pulse, sampled each edge
//   clear       in   1                synchronous flush/zero, active-high
//   evt_valid   out  1                head entry available
//   evt_ready   in   1                consumer accepts head when evt_valid=1
//   evt_ts      out  TS_W             head timestamp, 0 when empty
//   level       out  $clog2(DEPTH)+1  FIFO occupancy
//   evt_count   out  CNT_W            pulses seen (dropped included), saturating
//   drop_count  out  CNT_W            pulses lost to a full FIFO, saturating
//   overflow    out  1                sticky, set on first drop
//   evt_gap     out  TS_W             (EVLOG_GAP_EN only) head gap, 0 when empty
// ---------------------------------------------------------------------------
module detect_event_log #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     detected,
    input  logic                     clear,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         evt_count,
    output logic [CNT_W-1:0]         drop_count,
`ifdef EVLOG_GAP_EN
    output logic                     overflow,
    output logic [TS_W-1:0]          evt_gap
`else
    output logic                     overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_evt_count;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_overflow;
    logic [TS_W-1:0]  r_mem_ts [DEPTH];

    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;

    // clear masks both sides of the FIFO for the cycle it is asserted.
    assign w_pop      = (r_level != '0) && evt_ready && !clear;
    assign w_push_req = detected && !clear;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign w_push     = w_push_req && ((r_level != LVL_FULL) || w_pop);
    assign w_drop     = w_push_req && !w_push;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_evt_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (clear) begin
            r_ts         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_evt_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_push_req && (r_evt_count != CNT_MAX)) begin
                r_evt_count <= r_evt_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != CNT_MAX) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the entry storage has no reset; every output that reads it is
    // gated by level, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_ts;
        end
    end

`ifdef EVLOG_GAP_EN
    logic [TS_W-1:0] r_ts_prev;
    logic            r_have_prev;
    logic [TS_W-1:0] r_mem_gap [DEPTH];
    logic [TS_W-1:0] w_gap;

    // First accepted event after reset/clear has no predecessor: gap is 0.
    assign w_gap = r_have_prev ? (r_ts - r_ts_prev) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts_prev   <= '0;
            r_have_prev <= 1'b0;
        end else if (clear) begin
            r_ts_prev   <= '0;
            r_have_prev <= 1'b0;
        end else if (w_push) begin
            // Dropped events never reach here, so they do not move ts_prev.
            r_ts_prev   <= r_ts;
            r_have_prev <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_gap[r_wr_ptr] <= w_gap;
        end
    end

    always_comb begin
        evt_gap = '0;
        if (r_level != '0) begin
            evt_gap = r_mem_gap[r_rd_ptr];
        end
    end
`endif

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        evt_ts = '0;
        if (r_level != '0) begin
            evt_ts = r_mem_ts[r_rd_ptr];
        end
    end

    assign evt_valid  = (r_level != '0);
    assign level      = r_level;
    assign evt_count  = r_evt_count;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_detect_event_log.sv
// ---------------------------------------------------------------------------
// tb_detect_event_log
//
// Self-checking bench for detect_event_log. A default-parameter instance is
// exercised with a directed vector table, hand-written reset sequences and a
// randomized run scored against a queue-based model. A second instance with
// TS_W=4, CNT_W=2 covers timestamp wrap, gap (when EVLOG_GAP_EN is defined)
// and counter saturation.
// ---------------------------------------------------------------------------
module tb_detect_event_log;

    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             det, rdy, clr;
    logic             valid;
    logic [TS_W-1:0]  ts_o;
    logic [2:0]       lvl;
    logic [CNT_W-1:0] cnt, drp;
    logic             ovf;
`ifdef EVLOG_GAP_EN
    logic [TS_W-1:0]  gap;
`endif

    detect_event_log #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .detected   (det),
        .clear      (clr),
        .evt_valid  (valid),
        .evt_ready  (rdy),
        .evt_ts     (ts_o),
        .level      (lvl),
        .evt_count  (cnt),
        .drop_count (drp),
`ifdef EVLOG_GAP_EN
        .overflow   (ovf),
        .evt_gap    (gap)
`else
        .overflow   (ovf)
`endif
    );

    // Small instance: 4-bit timestamp, 2-bit counters.
    logic       s_det, s_rdy, s_clr;
    logic       s_valid;
    logic [3:0] s_ts;
    logic [2:0] s_lvl;
    logic [1:0] s_cnt, s_drp;
    logic       s_ovf;
`ifdef EVLOG_GAP_EN
    logic [3:0] s_gap;
`endif

    detect_event_log #(.DEPTH(4), .TS_W(4), .CNT_W(2)) u_small (
        .clk        (clk),
        .reset_n    (reset_n),
        .detected   (s_det),
        .clear      (s_clr),
        .evt_valid  (s_valid),
        .evt_ready  (s_rdy),
        .evt_ts     (s_ts),
        .level      (s_lvl),
        .evt_count  (s_cnt),
        .drop_count (s_drp),
`ifdef EVLOG_GAP_EN
        .overflow   (s_ovf),
        .evt_gap    (s_gap)
`else
        .overflow   (s_ovf)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int ts;
        int gap;
    } ent_t;

    ent_t m_q[$];
    int   m_ts, m_cnt, m_drop, m_prev;
    bit   m_ovf, m_have_prev;

    task automatic model_reset();
        m_q.delete();
        m_ts = 0; m_cnt = 0; m_drop = 0; m_prev = 0;
        m_ovf = 0; m_have_prev = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit d, input bit r, input bit c);
        ent_t e;
        if (c) begin
            model_reset();
            return;
        end
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (d) begin
            if (m_cnt < CMAX) m_cnt++;
            if (m_q.size() < DEPTH) begin
                e.ts  = m_ts;
                e.gap = m_have_prev ? ((m_ts - m_prev) & 16'hFFFF) : 0;
                m_q.push_back(e);
                m_prev      = m_ts;
                m_have_prev = 1;
            end else begin
                if (m_drop < CMAX) m_drop++;
                m_ovf = 1;
            end
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    task automatic compare_model(input string tag);
        int exp_ts;
        exp_ts = (m_q.size() > 0) ? m_q[0].ts : 0;
        check({tag, ".valid"}, 32'(valid), 32'(m_q.size() > 0));
        check({tag, ".ts"},    32'(ts_o),  32'(exp_ts));
        check({tag, ".level"}, 32'(lvl),   32'(m_q.size()));
        check({tag, ".count"}, 32'(cnt),   32'(m_cnt));
        check({tag, ".drop"},  32'(drp),   32'(m_drop));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
`ifdef EVLOG_GAP_EN
        check({tag, ".gap"},   32'(gap),   32'((m_q.size() > 0) ? m_q[0].gap : 0));
`endif
    endtask

    // Asserts reset across two edges; returns at a negedge with reset released,
    // so the next rising edge samples ts=0.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        det = 0; rdy = 0; clr = 0;
        s_det = 0; s_rdy = 0; s_clr = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit d, r, c;
        bit v;
        int ts, lv, ct, dr;
        bit ov;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(bit d, bit r, bit c, bit v, int ts, int lv, int ct, int dr, bit ov);
        vec_t x;
        x.d = d; x.r = r; x.c = c; x.v = v; x.ts = ts;
        x.lv = lv; x.ct = ct; x.dr = dr; x.ov = ov;
        return x;
    endfunction

    initial begin
        reset_n = 1'b0;
        det = 0; rdy = 0; clr = 0;
        s_det = 0; s_rdy = 0; s_clr = 0;

        // Row i is applied before edge i and therefore captures ts=i.
        //            d  r  c   v  ts  lv ct dr ov
        tbl[0]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,  1,  2, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0,  1,  2, 1, 1, 0, 0);
        tbl[4]  = mk(1, 0, 0,  1,  2, 2, 2, 0, 0);
        tbl[5]  = mk(0, 0, 0,  1,  2, 2, 2, 0, 0);
        tbl[6]  = mk(1, 0, 0,  1,  2, 3, 3, 0, 0);
        tbl[7]  = mk(0, 0, 0,  1,  2, 3, 3, 0, 0);
        tbl[8]  = mk(1, 0, 0,  1,  2, 4, 4, 0, 0);
        tbl[9]  = mk(0, 0, 0,  1,  2, 4, 4, 0, 0);
        tbl[10] = mk(1, 0, 0,  1,  2, 4, 5, 1, 1);   // full: dropped
        tbl[11] = mk(1, 1, 0,  1,  4, 4, 6, 1, 1);   // full push+pop: 11 becomes tail
        tbl[12] = mk(0, 1, 0,  1,  6, 3, 6, 1, 1);
        tbl[13] = mk(0, 1, 0,  1,  8, 2, 6, 1, 1);
        tbl[14] = mk(0, 1, 0,  1, 11, 1, 6, 1, 1);
        tbl[15] = mk(0, 1, 0,  0,  0, 0, 6, 1, 1);
        tbl[16] = mk(1, 1, 0,  1, 16, 1, 7, 1, 1);   // ready ignored when empty
        tbl[17] = mk(1, 1, 0,  1, 17, 1, 8, 1, 1);   // level=1 push+pop
        tbl[18] = mk(1, 0, 0,  1, 17, 2, 9, 1, 1);
        tbl[19] = mk(1, 0, 0,  1, 17, 3, 10, 1, 1);
        tbl[20] = mk(1, 1, 1,  0,  0, 0, 0, 0, 0);   // clear wins over push/pop
        tbl[21] = mk(1, 0, 0,  1,  0, 1, 1, 0, 0);   // ts restarted at 0

        // Reset state while reset is held.
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.ts",    32'(ts_o),  32'd0);
        check("rst.level", 32'(lvl),   32'd0);
        check("rst.count", 32'(cnt),   32'd0);
        check("rst.drop",  32'(drp),   32'd0);
        check("rst.ovf",   32'(ovf),   32'd0);

        // T1: pulse at ts=5.
        do_reset();
        repeat (5) begin
            @(posedge clk); @(negedge clk);
        end
        det = 1;
        @(posedge clk); #1;
        check("t1.valid", 32'(valid), 32'd1);
        check("t1.ts",    32'(ts_o),  32'd5);
        check("t1.level", 32'(lvl),   32'd1);
        check("t1.count", 32'(cnt),   32'd1);
        @(negedge clk);

        // T5: reset asserted between edges during a drain.
        det = 1;
        @(posedge clk); @(negedge clk);
        det = 0; rdy = 1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("t5.valid", 32'(valid), 32'd0);
        check("t5.level", 32'(lvl),   32'd0);
        check("t5.count", 32'(cnt),   32'd0);
        check("t5.ts",    32'(ts_o),  32'd0);
        @(negedge clk);
        rdy = 0;
        reset_n = 1'b1;

        // Vector table (T2/T3/T4 corners).
        do_reset();
        foreach (tbl[i]) begin
            det = tbl[i].d; rdy = tbl[i].r; clr = tbl[i].c;
            @(posedge clk); #1;
            check($sformatf("tbl%0d.valid", i), 32'(valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d.ts", i),    32'(ts_o),  32'(tbl[i].ts));
            check($sformatf("tbl%0d.level", i), 32'(lvl),   32'(tbl[i].lv));
            check($sformatf("tbl%0d.count", i), 32'(cnt),   32'(tbl[i].ct));
            check($sformatf("tbl%0d.drop", i),  32'(drp),   32'(tbl[i].dr));
            check($sformatf("tbl%0d.ovf", i),   32'(ovf),   32'(tbl[i].ov));
            @(negedge clk);
        end
        det = 0; rdy = 0; clr = 0;

        // Randomized run against the model: mixed traffic with occasional clear.
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            det = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 49) == 0);
            model_step(det, rdy, clr);
            @(posedge clk); #1;
            compare_model("rnd");
            @(negedge clk);
        end
        // Heavy traffic, no clear: drives both counters into saturation.
        for (int i = 0; i < 700; i++) begin
            det = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            clr = 0;
            model_step(det, rdy, clr);
            @(posedge clk); #1;
            compare_model("sat");
            @(negedge clk);
        end
        check("sat.count_max", 32'(cnt), 32'(CMAX));
        det = 0; rdy = 0; clr = 0;

        // T6 on the small instance: pulses at ts=14 and ts=2 (after wrap),
        // then three more so five pulses hit a 2-bit counter.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            s_det = (c == 14) || (c >= 18);
            @(posedge clk); #1;
            @(negedge clk);
        end
        s_det = 0;
        check("t6.count", 32'(s_cnt), 32'd3);
        check("t6.drop",  32'(s_drp), 32'd1);
        check("t6.ovf",   32'(s_ovf), 32'd1);
        check("t6.level", 32'(s_lvl), 32'd4);
        check("t6.ts0",   32'(s_ts),  32'd14);
`ifdef EVLOG_GAP_EN
        check("t6.gap0",  32'(s_gap), 32'd0);
`endif
        s_rdy = 1;
        @(posedge clk); #1;
        check("t6.ts1",    32'(s_ts),    32'd2);
        check("t6.level1", 32'(s_lvl),   32'd3);
        check("t6.valid1", 32'(s_valid), 32'd1);
`ifdef EVLOG_GAP_EN
        check("t6.gap1",   32'(s_gap),   32'd4);
`endif
        @(negedge clk);
        s_rdy = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
